// File: rtl/sqrt_rr_arbiter.sv
// sqrt_rr_arbiter: round-robin sequencer sharing one square-root unit among
// N_REQ requesters. A winner's operand is latched and held on s_o while
// doSqrt_o is high; the unit's result is captured on valid_i and returned with
// a one-cycle done_o pulse to that winner, who then drops to lowest priority.
// Optional feature macro: SQRT_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts
// after TIMEOUT_CYCLES with err_o=1 and a zero result.
module sqrt_rr_arbiter #(
  parameter  int N_REQ           = 4,
  parameter  int TIMEOUT_CYCLES  = 64,
  // Fraction width of the lampFPU float format (bfloat16-style, 7-bit fraction)
  localparam int LAMP_FLOAT_F_DW = 7,
  localparam int W               = 1 + LAMP_FLOAT_F_DW,
  localparam int RW              = 2 * W,
  localparam int IDW             = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0][W-1:0]   s_i,
  output logic                      doSqrt_o,
  output logic [W-1:0]              s_o,
  input  logic [RW-1:0]             res_i,
  input  logic                      valid_i,
  output logic [N_REQ-1:0]          done_o,
  output logic [RW-1:0]             res_o,
  output logic [IDW-1:0]            gnt_id_o,
  output logic                      busy_o,
  output logic                      err_o
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("sqrt_rr_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [W-1:0]    s_q, s_d;
  logic [RW-1:0]   res_q, res_d;
  logic [IDW-1:0]  win;
  logic            found;
  logic [IDW-1:0]  nxt_ptr;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout;
`endif

  // Rotating priority scan: first pending request starting at ptr_q
  always_comb begin
    logic [IDW-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Served requester becomes lowest priority: pointer moves just past it
  assign nxt_ptr = (gnt_q == IDW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

`ifdef SQRT_ARB_TIMEOUT_EN
  // Counter value TIMEOUT_CYCLES-1 marks the last allowed BUSY cycle
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state logic; valid_i wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    res_d   = res_q;
`ifdef SQRT_ARB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = win;
          s_d     = s_i[win];
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef SQRT_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (valid_i) begin
          res_d   = res_i;
          ptr_d   = nxt_ptr;
          state_d = DONE;
        end
`ifdef SQRT_ARB_TIMEOUT_EN
        else if (timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          ptr_d   = nxt_ptr;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      res_q   <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      res_q   <= res_d;
`ifdef SQRT_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // One-hot done pulse to the served requester, only in DONE
  always_comb begin
    done_o = '0;
    if (state_q == DONE) done_o[gnt_q] = 1'b1;
  end

  assign doSqrt_o = (state_q == BUSY);
  assign busy_o   = (state_q != IDLE);
  assign s_o      = s_q;
  assign res_o    = res_q;
  assign gnt_id_o = gnt_q;
`ifdef SQRT_ARB_TIMEOUT_EN
  assign err_o    = err_q;
`else
  assign err_o    = 1'b0;
`endif

endmodule
